// File: rtl/register_file_pkg.sv
// register_file_pkg
//   Shared definitions for the multi-port register file: the clear/run state
//   encoding, default parameter values and the register-0 suppression rule.
//   No ports (package).
package register_file_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int DEFAULT_XLEN           = 32;
    localparam int DEFAULT_REGS           = 32;
    localparam int DEFAULT_READ_PORTS     = 2;
    localparam int DEFAULT_HARDWIRED_ZERO = 1;

    // True when a write/reserve/read of addr acts on real storage; register 0
    // is a constant zero when the hardwired-zero option is enabled.
    function automatic logic regIndexValid(input logic [31:0] addr, input logic hardwiredZero);
        return !(hardwiredZero && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/register_file_multiport_if.sv
// register_file_multiport_if
//   Bus between the pipeline (decode/writeback, master side) and the register
//   file (slave side).
//   ready          : file has finished its post-reset clear
//   rsAddress/rs/rsPending : packed read ports (port i at [i*AW +: AW] / [i*XLEN +: XLEN])
//   rdAddress/rd/writeEnable : single write port
//   reserveAddress/reserveEnable : scoreboard reserve
//   debugAddress/debugOutput : storage observation tap
interface register_file_multiport_if
    import register_file_pkg::*;
#(
    parameter int XLEN       = DEFAULT_XLEN,
    parameter int REGS       = DEFAULT_REGS,
    parameter int READ_PORTS = DEFAULT_READ_PORTS
);
    localparam int AW = $clog2(REGS);

    logic                         ready;
    logic [READ_PORTS*AW-1:0]     rsAddress;
    logic [READ_PORTS*XLEN-1:0]   rs;
    logic [READ_PORTS-1:0]        rsPending;
    logic [AW-1:0]                rdAddress;
    logic [XLEN-1:0]              rd;
    logic                         writeEnable;
    logic [AW-1:0]                reserveAddress;
    logic                         reserveEnable;
    logic [AW-1:0]                debugAddress;
    logic [XLEN-1:0]              debugOutput;

    modport master (
        input  ready, rs, rsPending, debugOutput,
        output rsAddress, rdAddress, rd, writeEnable, reserveAddress, reserveEnable, debugAddress
    );

    modport slave (
        output ready, rs, rsPending, debugOutput,
        input  rsAddress, rdAddress, rd, writeEnable, reserveAddress, reserveEnable, debugAddress
    );

endinterface

// File: rtl/register_scoreboard.sv
// register_scoreboard
//   One pending bit per register. A reserve marks a register as awaiting a
//   producer; a write retires it. When both hit the same register in one
//   cycle the reserve wins, since it belongs to a newer producer.
//   clock, reset (sync, active-low, clears every bit in one cycle)
//   writeAddress/writeEnable     : retire request (already gated by caller)
//   reserveAddress/reserveEnable : reserve request (already gated by caller)
//   pending                      : current pending vector
module register_scoreboard
    import register_file_pkg::*;
#(
    parameter int REGS           = DEFAULT_REGS,
    parameter int HARDWIRED_ZERO = DEFAULT_HARDWIRED_ZERO
)(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [$clog2(REGS)-1:0]   writeAddress,
    input  logic                      writeEnable,
    input  logic [$clog2(REGS)-1:0]   reserveAddress,
    input  logic                      reserveEnable,
    output logic [REGS-1:0]           pending
);
    localparam int   AW     = $clog2(REGS);
    localparam logic HZ_BIT = (HARDWIRED_ZERO != 0);

    logic [REGS-1:0] pending_r;
    logic [REGS-1:0] pending_next_s;
    logic            write_ok_s;
    logic            reserve_ok_s;

    assign write_ok_s   = writeEnable   && regIndexValid(32'(writeAddress), HZ_BIT);
    assign reserve_ok_s = reserveEnable && regIndexValid(32'(reserveAddress), HZ_BIT);

    // Next pending vector: reserve beats write on the same register.
    always_comb begin
        pending_next_s = pending_r;
        for (int i = 0; i < REGS; i++) begin
            if (reserve_ok_s && (reserveAddress == AW'(i))) begin
                pending_next_s[i] = 1'b1;
            end else if (write_ok_s && (writeAddress == AW'(i))) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
        end
    end

    // Pending bit register with synchronous clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign pending = pending_r;

endmodule

// File: rtl/register_file_multiport.sv
// register_file_multiport
//   Parametrised multi-read-port register file with same-cycle write
//   forwarding, a pending-write scoreboard and a sequential post-reset clear.
//   Storage carries no reset so it can map onto RAM; instead a counter walks
//   every register writing zero after reset, and ready rises REGS cycles
//   after reset deasserts.
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of register_file_multiport_if (read/write/reserve/debug)
module register_file_multiport
    import register_file_pkg::*;
#(
    parameter int XLEN           = DEFAULT_XLEN,
    parameter int REGS           = DEFAULT_REGS,
    parameter int READ_PORTS     = DEFAULT_READ_PORTS,
    parameter int HARDWIRED_ZERO = DEFAULT_HARDWIRED_ZERO
)(
    input  logic                     clock,
    input  logic                     reset,
    register_file_multiport_if.slave bus
);
    localparam int   AW     = $clog2(REGS);
    localparam logic HZ_BIT = (HARDWIRED_ZERO != 0);

    rf_state_e                   state_r;
    rf_state_e                   state_next_s;
    logic [AW-1:0]               clear_index_r;
    logic [AW-1:0]               clear_index_next_s;
    logic                        clear_write_s;
    logic [XLEN-1:0]             storage_r [REGS];
    logic                        run_s;
    logic                        write_eff_s;
    logic                        reserve_eff_s;
    logic [REGS-1:0]             pending_s;
    logic [AW-1:0]               port_addr_s [READ_PORTS];
    logic [READ_PORTS*XLEN-1:0]  rs_s;
    logic [READ_PORTS-1:0]       rs_pending_s;
    logic [XLEN-1:0]             debug_s;

    // Outputs and updates are live only in RUN with reset released, so a
    // reset asserted mid-run silences reads and drops writes that same cycle.
    assign run_s         = reset && (state_r == RUN);
    assign write_eff_s   = run_s && bus.writeEnable && regIndexValid(32'(bus.rdAddress), HZ_BIT);
    assign reserve_eff_s = run_s && bus.reserveEnable;

    // Clear/run state and clear counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= CLEAR;
            clear_index_r <= '0;
        end else begin
            state_r       <= state_next_s;
            clear_index_r <= clear_index_next_s;
        end
    end

    // Clear FSM next-state: zero one register per cycle, then run forever.
    always_comb begin
        state_next_s       = state_r;
        clear_index_next_s = clear_index_r;
        clear_write_s      = 1'b0;
        case (state_r)
            CLEAR: begin
                clear_write_s      = 1'b1;
                clear_index_next_s = clear_index_r + AW'(1);
                if (clear_index_r == AW'(REGS - 1)) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = CLEAR;
                end
            end
            RUN: begin
                state_next_s = RUN;
            end
            default: begin
                state_next_s       = CLEAR;
                clear_index_next_s = '0;
            end
        endcase
    end

    // Reset-free storage: written only by the clear walker or the write port.
    always_ff @(posedge clock) begin
        if (reset && clear_write_s) begin
            storage_r[clear_index_r] <= '0;
        end else if (write_eff_s) begin
            storage_r[bus.rdAddress] <= bus.rd;
        end
    end

    register_scoreboard #(
        .REGS           (REGS),
        .HARDWIRED_ZERO (HARDWIRED_ZERO)
    ) u_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .writeAddress   (bus.rdAddress),
        .writeEnable    (write_eff_s),
        .reserveAddress (bus.reserveAddress),
        .reserveEnable  (reserve_eff_s),
        .pending        (pending_s)
    );

    // Read ports: constant zero for x0, forwarded write data on an address
    // match, otherwise storage plus its pending bit.
    always_comb begin
        rs_s         = '0;
        rs_pending_s = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            port_addr_s[i] = bus.rsAddress[i*AW +: AW];
            if (!run_s) begin
                rs_s[i*XLEN +: XLEN] = '0;
                rs_pending_s[i]      = 1'b0;
            end else if (!regIndexValid(32'(port_addr_s[i]), HZ_BIT)) begin
                rs_s[i*XLEN +: XLEN] = '0;
                rs_pending_s[i]      = 1'b0;
            end else if (write_eff_s && (port_addr_s[i] == bus.rdAddress)) begin
                rs_s[i*XLEN +: XLEN] = bus.rd;
                rs_pending_s[i]      = 1'b0;
            end else begin
                rs_s[i*XLEN +: XLEN] = storage_r[port_addr_s[i]];
                rs_pending_s[i]      = pending_s[port_addr_s[i]];
            end
        end
    end

    // Debug tap shows raw storage, never forwarded data.
    always_comb begin
        if (run_s) begin
            debug_s = storage_r[bus.debugAddress];
        end else begin
            debug_s = '0;
        end
    end

    assign bus.ready       = run_s;
    assign bus.rs          = rs_s;
    assign bus.rsPending   = rs_pending_s;
    assign bus.debugOutput = debug_s;

endmodule

// File: tb/tb_register_file_multiport.sv
// tb_register_file_multiport
//   Self-checking bench for two configurations: default (32x32, 2 ports) and
//   REGS=16, READ_PORTS=3, XLEN=64.
module tb_register_file_multiport;

    localparam int XA = 32;
    localparam int RA = 32;
    localparam int PA = 2;
    localparam int XB = 64;
    localparam int RB = 16;
    localparam int PB = 3;

    logic clock = 1'b0;
    logic resetA;
    logic resetB;
    int   total_checks = 0;
    int   passed_checks = 0;

    always #5 clock = ~clock;

    register_file_multiport_if #(.XLEN(XA), .REGS(RA), .READ_PORTS(PA)) busA ();
    register_file_multiport_if #(.XLEN(XB), .REGS(RB), .READ_PORTS(PB)) busB ();

    register_file_multiport #(.XLEN(XA), .REGS(RA), .READ_PORTS(PA), .HARDWIRED_ZERO(1)) dutA (
        .clock (clock),
        .reset (resetA),
        .bus   (busA)
    );

    register_file_multiport #(.XLEN(XB), .REGS(RB), .READ_PORTS(PB), .HARDWIRED_ZERO(1)) dutB (
        .clock (clock),
        .reset (resetB),
        .bus   (busB)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ep0;
        logic        ep1;
    } vec_t;

    vec_t vecs [12];

    // Reference model for DUT A: architectural contents and pending flags.
    logic [31:0] model_mem  [RA];
    logic        model_pend [RA];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic driveA(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic re, input logic [4:0] ra,
                          input logic [4:0] a0, input logic [4:0] a1);
        busA.writeEnable    = we;
        busA.rdAddress      = wa;
        busA.rd             = wd;
        busA.reserveEnable  = re;
        busA.reserveAddress = ra;
        busA.rsAddress      = {a1, a0};
    endtask

    // Counts cycles after reset release until ready, issuing random writes
    // and reserves during the clear; they must all be ignored.
    task automatic waitReadyA(output int cycles);
        cycles = 0;
        while (cycles < 100) begin
            driveA(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), 5'd0, 5'd0);
            #1;
            if (busA.ready) begin
                driveA(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
                break;
            end
            @(posedge clock);
            #1;
            cycles++;
        end
        driveA(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic waitReadyB(output int cycles);
        cycles = 0;
        #1;
        while (!busB.ready && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < RA; r++) begin
            model_mem[r]  = 32'd0;
            model_pend[r] = 1'b0;
        end
    endtask

    // Expected read of one port, from the architectural rules.
    task automatic modelRead(input logic [4:0] a, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd, output logic [31:0] v, output logic p);
        if (a == 5'd0) begin
            v = 32'd0;
            p = 1'b0;
        end else if (we && wa == a) begin
            v = wd;
            p = 1'b0;
        end else begin
            v = model_mem[a];
            p = model_pend[a];
        end
    endtask

    initial begin
        int          cycles;
        logic        we;
        logic        re;
        logic [4:0]  wa;
        logic [4:0]  ra;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [4:0]  dbg;
        logic [31:0] wd;
        logic [31:0] v0;
        logic [31:0] v1;
        logic        p0;
        logic        p1;

        // write/read, x0, forwarding, collision and pending sequences
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd7, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 5'd7, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'd9, 32'h1,        1'b1, 5'd9, 5'd9, 5'd9, 32'h1,        32'h1,        1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h1,        32'h1,        1'b1, 1'b1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 5'd4, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd4, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[11] = '{1'b1, 5'd3, 32'hAA,       1'b0, 5'd0, 5'd3, 5'd4, 32'hAA,       32'h0,        1'b0, 1'b1};

        resetA = 1'b0;
        resetB = 1'b0;
        driveA(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
        busA.debugAddress   = 5'd3;
        busB.writeEnable    = 1'b0;
        busB.rdAddress      = 4'd0;
        busB.rd             = 64'd0;
        busB.reserveEnable  = 1'b0;
        busB.reserveAddress = 4'd0;
        busB.rsAddress      = {4'd1, 4'd2, 4'd3};
        busB.debugAddress   = 4'd1;

        // ---- DUT A: reset state and clear sequence ----
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("A_reset_ready_c%0d", c), 64'(busA.ready), 64'd0);
            check($sformatf("A_reset_rs_c%0d", c), 64'(busA.rs), 64'd0);
            check($sformatf("A_reset_pend_c%0d", c), 64'(busA.rsPending), 64'd0);
            check($sformatf("A_reset_dbg_c%0d", c), 64'(busA.debugOutput), 64'd0);
        end
        resetA = 1'b1;
        waitReadyA(cycles);
        check("A_clear_cycles", 64'(cycles), 64'd32);
        for (int r = 0; r < RA; r++) begin
            busA.rsAddress    = {5'(r), 5'(r)};
            busA.debugAddress = 5'(r);
            #1;
            check($sformatf("A_clear_dbg_x%0d", r), 64'(busA.debugOutput), 64'd0);
            check($sformatf("A_clear_rs1_x%0d", r), 64'(busA.rs[63:32]), 64'd0);
            check($sformatf("A_clear_pend0_x%0d", r), 64'(busA.rsPending[0]), 64'd0);
        end

        // ---- DUT A: directed vector table ----
        for (int i = 0; i < 12; i++) begin
            driveA(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].a0, vecs[i].a1);
            #1;
            check($sformatf("vec%0d_rs0", i), 64'(busA.rs[31:0]), 64'(vecs[i].e0));
            check($sformatf("vec%0d_rs1", i), 64'(busA.rs[63:32]), 64'(vecs[i].e1));
            check($sformatf("vec%0d_pend0", i), 64'(busA.rsPending[0]), 64'(vecs[i].ep0));
            check($sformatf("vec%0d_pend1", i), 64'(busA.rsPending[1]), 64'(vecs[i].ep1));
            tick();
        end
        driveA(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
        busA.debugAddress = 5'd3;
        #1;
        check("A_pre_reset_x3", 64'(busA.rs[31:0]), 64'hAA);
        check("A_pre_reset_dbg_x3", 64'(busA.debugOutput), 64'hAA);
        check("A_pre_reset_pend_x4", 64'(busA.rsPending[1]), 64'd1);

        // ---- DUT A: reset pulse mid-run; write in the reset cycle is dropped ----
        resetA = 1'b0;
        driveA(1'b1, 5'd6, 32'h55, 1'b0, 5'd0, 5'd3, 5'd4);
        #1;
        check("A_midreset_pend_immediate", 64'(busA.rsPending), 64'd0);
        check("A_midreset_ready", 64'(busA.ready), 64'd0);
        tick();
        resetA = 1'b1;
        waitReadyA(cycles);
        check("A_midreset_clear_cycles", 64'(cycles), 64'd32);
        driveA(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
        busA.debugAddress = 5'd6;
        #1;
        check("A_after_reset_x3", 64'(busA.rs[31:0]), 64'd0);
        check("A_after_reset_pend_x4", 64'(busA.rsPending[1]), 64'd0);
        check("A_after_reset_x6_dropped", 64'(busA.debugOutput), 64'd0);

        // ---- DUT A: randomized traffic against the reference model ----
        modelReset();
        for (int n = 0; n < 400; n++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 7));
            wd  = $urandom;
            re  = ($urandom_range(0, 3) == 0);
            ra  = 5'($urandom_range(0, 7));
            a0  = 5'($urandom_range(0, 7));
            a1  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
            dbg = 5'($urandom_range(0, 7));
            driveA(we, wa, wd, re, ra, a0, a1);
            busA.debugAddress = dbg;
            #1;
            modelRead(a0, we, wa, wd, v0, p0);
            modelRead(a1, we, wa, wd, v1, p1);
            check($sformatf("rnd%0d_rs0", n), 64'(busA.rs[31:0]), 64'(v0));
            check($sformatf("rnd%0d_rs1", n), 64'(busA.rs[63:32]), 64'(v1));
            check($sformatf("rnd%0d_pend0", n), 64'(busA.rsPending[0]), 64'(p0));
            check($sformatf("rnd%0d_pend1", n), 64'(busA.rsPending[1]), 64'(p1));
            check($sformatf("rnd%0d_dbg", n), 64'(busA.debugOutput), 64'(model_mem[dbg]));
            tick();
            if (we && wa != 5'd0) begin
                model_mem[wa]  = wd;
                model_pend[wa] = 1'b0;
            end
            if (re && ra != 5'd0) begin
                model_pend[ra] = 1'b1;
            end
        end
        driveA(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

        // ---- DUT B: 16 regs, 3 ports, 64-bit ----
        #1;
        check("B_reset_ready", 64'(busB.ready), 64'd0);
        check("B_reset_pend", 64'(busB.rsPending), 64'd0);
        tick();
        resetB = 1'b1;
        waitReadyB(cycles);
        check("B_clear_cycles", 64'(cycles), 64'd16);
        busB.writeEnable = 1'b1;
        busB.rdAddress   = 4'd5;
        busB.rd          = 64'h0123_4567_89AB_CDEF;
        busB.rsAddress   = {4'd5, 4'd5, 4'd5};
        busB.debugAddress = 4'd5;
        #1;
        for (int p = 0; p < PB; p++) begin
            check($sformatf("B_fwd_port%0d", p), busB.rs[p*64 +: 64], 64'h0123_4567_89AB_CDEF);
        end
        check("B_dbg_no_forward", busB.debugOutput, 64'd0);
        tick();
        busB.writeEnable    = 1'b0;
        busB.reserveEnable  = 1'b1;
        busB.reserveAddress = 4'd2;
        busB.rsAddress      = {4'd2, 4'd5, 4'd5};
        #1;
        check("B_store_port0", busB.rs[63:0], 64'h0123_4567_89AB_CDEF);
        check("B_store_port1", busB.rs[127:64], 64'h0123_4567_89AB_CDEF);
        check("B_dbg_store", busB.debugOutput, 64'h0123_4567_89AB_CDEF);
        check("B_reserve_same_cycle", 64'(busB.rsPending[2]), 64'd0);
        tick();
        busB.reserveEnable = 1'b0;
        #1;
        check("B_reserve_next_cycle", 64'(busB.rsPending[2]), 64'd1);
        resetB = 1'b0;
        #1;
        check("B_midreset_pend_immediate", 64'(busB.rsPending), 64'd0);
        check("B_midreset_ready", 64'(busB.ready), 64'd0);
        tick();
        resetB = 1'b1;
        waitReadyB(cycles);
        check("B_midreset_clear_cycles", 64'(cycles), 64'd16);
        #1;
        check("B_after_reset_x5", busB.rs[127:64], 64'd0);
        check("B_after_reset_pend_x2", 64'(busB.rsPending[2]), 64'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
